fft_frame_sequencer: RTL and testbench

Streaming front/back-end controller for the 16-point FFT core. It accepts complex samples one per handshake, assembles them into the core's flat 256-bit real/imag buses, and issues a one-cycle `core_start`. It then waits for `core_done`, captures the 16 output bins, and streams them out in bin order with a valid/ready handshake. It sits between a sample source (ADC/DMA) and any FFT core variant (radix-2, radix-4, radix-2²) sharing the `start`/`done`/flat-bus interface.

---
 rtl/fft_frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Streaming front/back-end controller for a 16-point FFT core. Collects 16
// complex samples, presents them as flat buses with a one-cycle core_start,
// waits for core_done, captures the bins and streams them out in bin order.
// Optional build macro: FFT_SEQ_TIMEOUT_EN enables a WAIT-state watchdog that
// abandons the frame and raises a sticky err after TIMEOUT_CYCLES cycles.

module fft_frame_sequencer #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_real,
  input  logic signed [WIDTH-1:0] s_imag,
  output logic                    core_start,
  output logic [WIDTH*16-1:0]     core_in_real,
  output logic [WIDTH*16-1:0]     core_in_imag,
  input  logic                    core_done,
  input  logic [WIDTH*16-1:0]     core_out_real,
  input  logic [WIDTH*16-1:0]     core_out_imag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_real,
  output logic signed [WIDTH-1:0] m_imag,
  output logic [3:0]              m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err,
  output logic [15:0]             frame_count
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  wr_idx_q, wr_idx_d;
  logic [3:0]  rd_idx_q, rd_idx_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        busy_q, busy_d;

  logic signed [WIDTH-1:0] in_real_q  [16];
  logic signed [WIDTH-1:0] in_real_d  [16];
  logic signed [WIDTH-1:0] in_imag_q  [16];
  logic signed [WIDTH-1:0] in_imag_d  [16];
  logic signed [WIDTH-1:0] out_real_q [16];
  logic signed [WIDTH-1:0] out_real_d [16];
  logic signed [WIDTH-1:0] out_imag_q [16];
  logic signed [WIDTH-1:0] out_imag_d [16];

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Next-state, buffer write, capture and handshake bookkeeping
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    frame_count_d = frame_count_q;
    in_real_d     = in_real_q;
    in_imag_d     = in_imag_q;
    out_real_d    = out_real_q;
    out_imag_d    = out_imag_q;
`ifdef FFT_SEQ_TIMEOUT_EN
    err_d         = err_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          in_real_d[wr_idx_q] = s_real;
          in_imag_d[wr_idx_q] = s_imag;
          wr_idx_d            = wr_idx_q + 4'd1;
          if (wr_idx_q == 4'd15) begin
            state_d = ST_FIRE;
          end
        end
      end
      ST_FIRE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          for (int k = 0; k < 16; k++) begin
            out_real_d[k] = core_out_real[k*WIDTH +: WIDTH];
            out_imag_d[k] = core_out_imag[k*WIDTH +: WIDTH];
          end
          state_d = ST_DRAIN;
        end
`ifdef FFT_SEQ_TIMEOUT_EN
        else if (timeout_cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end
`endif
      end
      ST_DRAIN: begin
        if (m_ready) begin
          rd_idx_d = rd_idx_q + 4'd1;
          if (rd_idx_q == 4'd15) begin
            state_d       = ST_LOAD;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    busy_d = (state_d != ST_LOAD);
  end

  // State, index, counter and buffer registers; reset clears both buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      wr_idx_q      <= 4'd0;
      rd_idx_q      <= 4'd0;
      frame_count_q <= 16'd0;
      busy_q        <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        in_real_q[k]  <= '0;
        in_imag_q[k]  <= '0;
        out_real_q[k] <= '0;
        out_imag_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      in_real_q     <= in_real_d;
      in_imag_q     <= in_imag_d;
      out_real_q    <= out_real_d;
      out_imag_q    <= out_imag_d;
    end
  end

`ifdef FFT_SEQ_TIMEOUT_EN
  // Watchdog count: cleared while firing, advances every cycle spent waiting
  always_comb begin
    timeout_cnt_d = timeout_cnt_q;
    if (state_q == ST_FIRE) begin
      timeout_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      timeout_cnt_d = timeout_cnt_q + TO_W'(1);
    end
  end

  // Watchdog count and sticky error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
      err_q         <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Flatten the input buffer onto the core buses; slot k sits at k*WIDTH
  always_comb begin
    core_in_real = '0;
    core_in_imag = '0;
    for (int k = 0; k < 16; k++) begin
      core_in_real[k*WIDTH +: WIDTH] = in_real_q[k];
      core_in_imag[k*WIDTH +: WIDTH] = in_imag_q[k];
    end
  end

  assign s_ready     = (state_q == ST_LOAD);
  assign core_start  = (state_q == ST_FIRE);
  assign m_valid     = (state_q == ST_DRAIN);
  assign m_real      = m_valid ? out_real_q[rd_idx_q] : '0;
  assign m_imag      = m_valid ? out_imag_q[rd_idx_q] : '0;
  assign m_index     = rd_idx_q;
  assign m_last      = m_valid && (rd_idx_q == 4'd15);
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer
// Scoreboard bench for fft_frame_sequencer. A stub core echoes its input
// buses back as results a fixed number of cycles after core_start, so every
// frame's expected bins are the samples fed in. Timeout scenario runs only
// when FFT_SEQ_TIMEOUT_EN is defined.

module tb_fft_frame_sequencer;

  localparam int W = 16;
  localparam logic [W*16-1:0] JUNK = {16{16'hDEAD}};

  logic                clk;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_real;
  logic signed [W-1:0] s_imag;
  logic                core_start;
  logic [W*16-1:0]     core_in_real;
  logic [W*16-1:0]     core_in_imag;
  logic                core_done;
  logic [W*16-1:0]     core_out_real;
  logic [W*16-1:0]     core_out_imag;
  logic                m_valid;
  logic                m_ready;
  logic signed [W-1:0] m_real;
  logic signed [W-1:0] m_imag;
  logic [3:0]          m_index;
  logic                m_last;
  logic                busy;
  logic                err;
  logic [15:0]         frame_count;

  logic stub_done;
  logic tb_done;
  assign core_done = stub_done | tb_done;

  fft_frame_sequencer #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_real        (s_real),
    .s_imag        (s_imag),
    .core_start    (core_start),
    .core_in_real  (core_in_real),
    .core_in_imag  (core_in_imag),
    .core_done     (core_done),
    .core_out_real (core_out_real),
    .core_out_imag (core_out_imag),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_real        (m_real),
    .m_imag        (m_imag),
    .m_index       (m_index),
    .m_last        (m_last),
    .busy          (busy),
    .err           (err),
    .frame_count   (frame_count)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic [3:0]          idx;
    logic                last;
  } bin_t;

  bin_t sb[$];

  int checks_total  = 0;
  int checks_passed = 0;

  logic signed [W-1:0] fr_re [16];
  logic signed [W-1:0] fr_im [16];

  int stub_latency = 10;
  bit stub_never   = 1'b0;
  int stub_pending = 0;
  int ready_mode   = 0;

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [W*16-1:0] flatten(input bit use_imag);
    logic [W*16-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[k*W +: W] = use_imag ? fr_im[k] : fr_re[k];
    end
    return v;
  endfunction

  // Stub core: echoes core_in as results stub_latency cycles after core_start
  initial begin
    stub_done     = 1'b0;
    core_out_real = JUNK;
    core_out_imag = JUNK;
    forever begin
      @(posedge clk);
      #1;
      stub_done     = 1'b0;
      core_out_real = JUNK;
      core_out_imag = JUNK;
      if (core_start && !stub_never) begin
        stub_pending = stub_latency;
      end else if (stub_pending > 0) begin
        stub_pending--;
        if (stub_pending == 0) begin
          stub_done     = 1'b1;
          core_out_real = core_in_real;
          core_out_imag = core_in_imag;
        end
      end
    end
  end

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, other stalled
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = !m_ready;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: per-cycle control checks, scoreboard pops, stall stability
  int                  hs_cnt       = 0;
  logic                exp_start    = 1'b0;
  logic                busy_model   = 1'b0;
  logic                err_seen     = 1'b0;
  logic                hold_pending = 1'b0;
  logic signed [W-1:0] hold_re;
  logic signed [W-1:0] hold_im;
  logic [3:0]          hold_idx;

  always @(negedge clk) begin
    bin_t e;
    if (rst) begin
      hs_cnt       = 0;
      exp_start    = 1'b0;
      busy_model   = 1'b0;
      err_seen     = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (err && !err_seen) begin
        busy_model = 1'b0;
      end
      err_seen = err;
      checkOutput("core_start", core_start, exp_start);
      checkOutput("busy", busy, busy_model);
      checkOutput("s_ready", s_ready, !busy_model);
      if (hold_pending) begin
        checkOutput("stall_valid", m_valid, 1'b1);
        checkOutput("stall_real", m_real, hold_re);
        checkOutput("stall_imag", m_imag, hold_im);
        checkOutput("stall_index", m_index, hold_idx);
        hold_pending = 1'b0;
      end
      if (m_valid) begin
        if (sb.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL unexpected_bin: got m_valid=1 index %0d expected no output", m_index);
        end else if (m_ready) begin
          e = sb.pop_front();
          checkOutput("bin_real", m_real, e.re);
          checkOutput("bin_imag", m_imag, e.im);
          checkOutput("bin_index", m_index, e.idx);
          checkOutput("bin_last", m_last, e.last);
          if (e.last) begin
            busy_model = 1'b0;
          end
        end else begin
          hold_pending = 1'b1;
          hold_re      = m_real;
          hold_im      = m_imag;
          hold_idx     = m_index;
        end
      end
      exp_start = 1'b0;
      if (s_valid && s_ready) begin
        hs_cnt++;
        if (hs_cnt == 16) begin
          hs_cnt     = 0;
          exp_start  = 1'b1;
          busy_model = 1'b1;
        end
      end
    end
  end

  // Feed fr_re/fr_im as one frame; optionally queue the echoed bins
  task automatic applyStimulus(input bit gaps, input bit push_exp);
    bin_t e;
    bit   rdy;
    int   guard;
    if (push_exp) begin
      for (int k = 0; k < 16; k++) begin
        e.re   = fr_re[k];
        e.im   = fr_im[k];
        e.idx  = 4'(k);
        e.last = (k == 15);
        sb.push_back(e);
      end
    end
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 0; g++) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_real  = fr_re[k];
      s_imag  = fr_im[k];
      guard   = 0;
      do begin
        rdy = s_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!rdy && guard < 300);
      if (!rdy) begin
        checks_total++;
        $display("[TB] FAIL load_timeout: sample %0d got s_ready=0 expected 1 within 300 cycles", k);
      end
      s_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 400) begin
      checks_total++;
      $display("[TB] FAIL drain_timeout: got %0d bins pending expected 0", sb.size());
    end
  endtask

  task automatic applyReset(input int cycles);
    rst     = 1'b1;
    s_valid = 1'b0;
    tb_done = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_s_ready"}, s_ready, 1'b1);
    checkOutput({tag, "_core_start"}, core_start, 1'b0);
    checkOutput({tag, "_m_valid"}, m_valid, 1'b0);
    checkOutput({tag, "_m_last"}, m_last, 1'b0);
    checkOutput({tag, "_m_index"}, m_index, 4'd0);
    checkOutput({tag, "_m_real"}, m_real, 16'd0);
    checkOutput({tag, "_m_imag"}, m_imag, 16'd0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_err"}, err, 1'b0);
    checkOutput({tag, "_frame_count"}, frame_count, 16'd0);
    checkOutput({tag, "_core_in_real"}, core_in_real, 256'd0);
    checkOutput({tag, "_core_in_imag"}, core_in_imag, 256'd0);
  endtask

  // Safety net against a hung run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion expected finish within 40000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence
  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_real  = '0;
    s_imag  = '0;
    tb_done = 1'b0;
    #1;
    applyReset(3);
    checkResetState("por");

    $display("[TB] core_done during LOAD must be ignored");
    tb_done = 1'b1;
    @(posedge clk);
    #1;
    tb_done = 1'b0;
    checkOutput("stray_done_m_valid", m_valid, 1'b0);
    checkOutput("stray_done_s_ready", s_ready, 1'b1);

    $display("[TB] impulse frame");
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = (k == 0) ? 16'sd32767 : 16'sd0;
      fr_im[k] = 16'sd0;
    end
    ready_mode = 0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("impulse_start", core_start, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("impulse_in_lsb", core_in_real[15:0], 16'h7fff);
    checkOutput("impulse_in_real", core_in_real, flatten(1'b0));
    checkOutput("impulse_in_imag", core_in_imag, flatten(1'b1));
    waitIdle();
    checkOutput("fc_impulse", frame_count, 16'd1);

    $display("[TB] backpressure frame");
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = W'(100 * k + 1);
      fr_im[k] = W'(-(k + 1) * 3);
    end
    ready_mode = 1;
    applyStimulus(1'b0, 1'b1);
    waitIdle();
    checkOutput("fc_backpressure", frame_count, 16'd2);

    $display("[TB] input gaps with random ready");
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = W'(k);
      fr_im[k] = W'(15 - k);
    end
    ready_mode = 2;
    applyStimulus(1'b1, 1'b1);
    waitIdle();
    checkOutput("fc_gaps", frame_count, 16'd3);

    $display("[TB] reset during WAIT");
    ready_mode   = 0;
    stub_latency = 40;
    applyStimulus(1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midwait_busy", busy, 1'b1);
    applyReset(1);
    checkResetState("midwait");
    stub_latency = 10;

    $display("[TB] reset during DRAIN");
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = W'(7 * k - 50);
      fr_im[k] = W'(k);
    end
    ready_mode = 3;
    applyStimulus(1'b0, 1'b1);
    begin
      int guard;
      guard = 0;
      while (!m_valid && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      checkOutput("middrain_valid", m_valid, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    applyReset(1);
    checkResetState("middrain");
    ready_mode = 0;
    applyStimulus(1'b0, 1'b1);
    waitIdle();
    checkOutput("fc_after_reset", frame_count, 16'd1);

    $display("[TB] three back-to-back frames");
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = W'(k);
      fr_im[k] = 16'sd0;
    end
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = W'(2 * k);
      fr_im[k] = 16'sd0;
    end
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = -16'sd1;
      fr_im[k] = 16'sd0;
    end
    applyStimulus(1'b0, 1'b1);
    waitIdle();
    checkOutput("fc_back_to_back", frame_count, 16'd4);

`ifdef FFT_SEQ_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    stub_never = 1'b1;
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = W'(k + 1000);
      fr_im[k] = W'(k);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("to_start", core_start, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("to_err_before", err, 1'b0);
    checkOutput("to_busy_before", busy, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("to_err_set", err, 1'b1);
    checkOutput("to_s_ready", s_ready, 1'b1);
    checkOutput("to_busy_after", busy, 1'b0);
    checkOutput("to_frame_count", frame_count, 16'd4);
    tb_done = 1'b1;
    @(posedge clk);
    #1;
    tb_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("late_done_m_valid", m_valid, 1'b0);
    checkOutput("late_done_frame_count", frame_count, 16'd4);
    checkOutput("late_done_err_sticky", err, 1'b1);
`else
    repeat (5) @(posedge clk);
    #1;
    checkOutput("err_tied_low", err, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
